// File: rtl/fetch_buffer.sv
// Thread-tagged fetch->decode FIFO with per-thread selective kill on execute redirects.
// Optional same-cycle fetch->decode bypass when empty: define FETCH_BUFFER_BYPASS_EN.
module fetch_buffer #(
    parameter  int DATA_WIDTH    = 32,
    parameter  int ADDRESS_WIDTH = 32,
    parameter  int NUM_THREADS   = 4,
    parameter  int DEPTH         = 4,
    localparam int BITS_THREADS  = $clog2(NUM_THREADS),
    localparam int PTR_W         = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_f,
    output logic                     ready_f,
    input  logic [DATA_WIDTH-1:0]    instr_f,
    input  logic [ADDRESS_WIDTH-1:0] pc_f,
    input  logic [ADDRESS_WIDTH-1:0] pc_plus4_f,
    input  logic [BITS_THREADS-1:0]  tid_f,
    input  logic                     pc_src_e,
    input  logic [BITS_THREADS-1:0]  tid_e,
    output logic                     valid_d,
    input  logic                     ready_d,
    output logic [DATA_WIDTH-1:0]    instr_d,
    output logic [ADDRESS_WIDTH-1:0] pc_d,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_d,
    output logic [BITS_THREADS-1:0]  tid_d,
    output logic [PTR_W:0]           count
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   ZERO_CNT = {(PTR_W+1){1'b0}};
    localparam logic [PTR_W:0]   ONE_CNT  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] ONE_PTR  = {{(PTR_W-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0]    r_instr [DEPTH];
    logic [ADDRESS_WIDTH-1:0] r_pc    [DEPTH];
    logic [ADDRESS_WIDTH-1:0] r_pc4   [DEPTH];
    logic [BITS_THREADS-1:0]  r_tid   [DEPTH];
    logic [DEPTH-1:0]         r_live;
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [PTR_W:0]           r_count;
    logic                     r_ready_f;

    logic                     w_kill_in;
    logic [DEPTH-1:0]         w_kill_slot;
    logic [DEPTH-1:0]         w_live_next;
    logic                     w_head_live;
    logic                     w_bypass;
    logic                     w_bypass_take;
    logic                     w_push;
    logic                     w_pop;
    logic [PTR_W:0]           w_count_next;

`ifdef FETCH_BUFFER_BYPASS_EN
    assign w_bypass = (r_count == ZERO_CNT) && valid_f && !w_kill_in;
`else
    assign w_bypass = 1'b0;
`endif
    assign w_bypass_take = w_bypass && ready_d;

    // Redirect kill masks for the incoming entry and every stored slot.
    always_comb begin
        w_kill_in   = pc_src_e && (tid_f == tid_e);
        w_kill_slot = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            w_kill_slot[i] = pc_src_e && (r_tid[i] == tid_e);
        end
    end

    // Killed heads are dropped one per cycle regardless of decode readiness.
    assign w_head_live = (r_count != ZERO_CNT) && r_live[r_rd_ptr] && !w_kill_slot[r_rd_ptr];
    assign w_push      = valid_f && r_ready_f && !w_bypass_take;
    assign w_pop       = (w_head_live && ready_d) || ((r_count != ZERO_CNT) && !w_head_live);

    // Next live bits: kill matching threads, clear the popped slot, set the pushed slot.
    always_comb begin
        w_live_next = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            w_live_next[i] = (w_push && (PTR_W'(i) == r_wr_ptr)) ? !w_kill_in :
                             (r_live[i] && !w_kill_slot[i] && !(w_pop && (PTR_W'(i) == r_rd_ptr)));
        end
    end

    // Occupancy update; push and pop together leave it unchanged.
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + ONE_CNT;
            2'b01:   w_count_next = r_count - ONE_CNT;
            default: w_count_next = r_count;
        endcase
    end

    // Control state: pointers, occupancy, live bits and the registered ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= {PTR_W{1'b0}};
            r_rd_ptr  <= {PTR_W{1'b0}};
            r_count   <= ZERO_CNT;
            r_live    <= {DEPTH{1'b0}};
            r_ready_f <= 1'b1;
        end else begin
            r_wr_ptr  <= w_push ? r_wr_ptr + ONE_PTR : r_wr_ptr;
            r_rd_ptr  <= w_pop ? r_rd_ptr + ONE_PTR : r_rd_ptr;
            r_count   <= w_count_next;
            r_live    <= w_live_next;
            r_ready_f <= (w_count_next != FULL_CNT);
        end
    end

    // Payload storage; contents of unoccupied slots are never observed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr[r_wr_ptr] <= instr_f;
            r_pc[r_wr_ptr]    <= pc_f;
            r_pc4[r_wr_ptr]   <= pc_plus4_f;
            r_tid[r_wr_ptr]   <= tid_f;
        end
    end

    // Decode-side presentation: bypass, head slot, or zeros when empty.
    always_comb begin
        valid_d    = w_head_live;
        instr_d    = {DATA_WIDTH{1'b0}};
        pc_d       = {ADDRESS_WIDTH{1'b0}};
        pc_plus4_d = {ADDRESS_WIDTH{1'b0}};
        tid_d      = {BITS_THREADS{1'b0}};
        if (w_bypass) begin
            valid_d    = 1'b1;
            instr_d    = instr_f;
            pc_d       = pc_f;
            pc_plus4_d = pc_plus4_f;
            tid_d      = tid_f;
        end else if (r_count != ZERO_CNT) begin
            instr_d    = r_instr[r_rd_ptr];
            pc_d       = r_pc[r_rd_ptr];
            pc_plus4_d = r_pc4[r_rd_ptr];
            tid_d      = r_tid[r_rd_ptr];
        end else begin
            valid_d    = 1'b0;
        end
    end

    assign ready_f = r_ready_f;
    assign count   = r_count;

endmodule
